// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } arb_state_e;

    localparam int unsigned NUM_PORTS     = 2;
    localparam int unsigned CNT_W         = 8;
    localparam logic [7:0]  TIMEOUT_RDATA = 8'hFF;

endpackage

// File: rtl/ram_arb_rr.sv
// Combinational winner select: fixed (lowest index wins) or round-robin
// starting from the port after the last one granted.
module ram_arb_rr #(
    parameter int unsigned N              = 2,
    parameter bit          FIXED_PRIORITY = 1'b0,
    localparam int unsigned IW            = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] gnt
);

    logic [IW-1:0] idx;

    always_comb begin
        valid = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = FIXED_PRIORITY ? IW'(i) : IW'((32'(last) + 1 + i) % N);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                gnt   = idx;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises two requesters onto one byte-wide RAM port with a
// request/acknowledge handshake and a BUSY-state timeout.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 22,
    parameter bit          FIXED_PRIORITY = 1'b0,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic                  CLK,
    input  logic                  RESET_n,
    input  logic [1:0]            REQ,
    input  logic [1:0]            WE,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    input  logic [7:0]            WDATA0,
    input  logic [7:0]            WDATA1,
    output logic [1:0]            ACK,
    output logic [7:0]            RDATA0,
    output logic [7:0]            RDATA1,
    output logic [1:0]            ERR,
    output logic                  RAM_REQ,
    output logic                  RAM_WE,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic [7:0]            RAM_WDATA,
    input  logic                  RAM_ACK,
    input  logic [7:0]            RAM_RDATA
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e            state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_q, last_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ram_req_q, ram_req_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]            ram_wdata_q, ram_wdata_d;
    logic [1:0]            ack_q, ack_d;
    logic [1:0]            err_q, err_d;
    logic [7:0]            rdata0_q, rdata0_d;
    logic [7:0]            rdata1_q, rdata1_d;

    logic       arb_valid;
    logic       arb_gnt;
    logic [7:0] done_rdata;

    ram_arb_rr #(
        .N              (NUM_PORTS),
        .FIXED_PRIORITY (FIXED_PRIORITY)
    ) u_arb (
        .req   (REQ),
        .last  (last_q),
        .valid (arb_valid),
        .gnt   (arb_gnt)
    );

    // Completion data: real RAM data wins over the timeout filler.
    assign done_rdata = RAM_ACK ? RAM_RDATA : TIMEOUT_RDATA;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ack_d       = '0;
        err_d       = '0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d     = arb_gnt;
                    ram_we_d    = WE[arb_gnt];
                    ram_addr_d  = arb_gnt ? ADDR1 : ADDR0;
                    ram_wdata_d = arb_gnt ? WDATA1 : WDATA0;
                    cnt_d       = '0;
                    ram_req_d   = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (RAM_ACK || (cnt_q == CNT_LAST)) begin
                    state_d        = DONE;
                    ram_req_d      = 1'b0;
                    last_d         = grant_q;
                    ack_d[grant_q] = 1'b1;
                    err_d[grant_q] = !RAM_ACK;
                    if (!ram_we_q) begin
                        if (grant_q) rdata1_d = done_rdata;
                        else         rdata0_d = done_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ack_q       <= '0;
            err_q       <= '0;
            rdata0_q    <= TIMEOUT_RDATA;
            rdata1_q    <= TIMEOUT_RDATA;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign ACK       = ack_q;
    assign ERR       = err_q;
    assign RDATA0    = rdata0_q;
    assign RDATA1    = rdata1_q;
    assign RAM_REQ   = ram_req_q;
    assign RAM_WE    = ram_we_q;
    assign RAM_ADDR  = ram_addr_q;
    assign RAM_WDATA = ram_wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share stimulus.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we;
    logic [21:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        ram_ack;
    logic [7:0]  ram_rdata;

    logic [1:0]  r_ack, r_err, f_ack, f_err;
    logic [7:0]  r_rdata0, r_rdata1, f_rdata0, f_rdata1;
    logic        r_ram_req, r_ram_we, f_ram_req, f_ram_we;
    logic [21:0] r_ram_addr, f_ram_addr;
    logic [7:0]  r_ram_wdata, f_ram_wdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(22), .FIXED_PRIORITY(1'b0), .TIMEOUT(4)) dut_rr (
        .CLK(clk), .RESET_n(rst_n), .REQ(req), .WE(we),
        .ADDR0(addr0), .ADDR1(addr1), .WDATA0(wdata0), .WDATA1(wdata1),
        .ACK(r_ack), .RDATA0(r_rdata0), .RDATA1(r_rdata1), .ERR(r_err),
        .RAM_REQ(r_ram_req), .RAM_WE(r_ram_we), .RAM_ADDR(r_ram_addr),
        .RAM_WDATA(r_ram_wdata), .RAM_ACK(ram_ack), .RAM_RDATA(ram_rdata)
    );

    ram_arbiter #(.ADDR_WIDTH(22), .FIXED_PRIORITY(1'b1), .TIMEOUT(4)) dut_fx (
        .CLK(clk), .RESET_n(rst_n), .REQ(req), .WE(we),
        .ADDR0(addr0), .ADDR1(addr1), .WDATA0(wdata0), .WDATA1(wdata1),
        .ACK(f_ack), .RDATA0(f_rdata0), .RDATA1(f_rdata1), .ERR(f_err),
        .RAM_REQ(f_ram_req), .RAM_WE(f_ram_we), .RAM_ADDR(f_ram_addr),
        .RAM_WDATA(f_ram_wdata), .RAM_ACK(ram_ack), .RAM_RDATA(ram_rdata)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0; req = '0; we = '0; addr0 = '0; addr1 = '0;
        wdata0 = '0; wdata1 = '0; ram_ack = 1'b0; ram_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset();
        vectors++; if (r_ack !== 2'b00) begin miscompares++; $display("FAIL reset_ack got %b want 00", r_ack); end
        vectors++; if (r_err !== 2'b00) begin miscompares++; $display("FAIL reset_err got %b want 00", r_err); end
        vectors++; if (r_ram_req !== 1'b0 || r_ram_we !== 1'b0) begin miscompares++; $display("FAIL reset_ram_req_we got %b%b want 00", r_ram_req, r_ram_we); end
        vectors++; if (r_ram_addr !== 22'h0 || r_ram_wdata !== 8'h00) begin miscompares++; $display("FAIL reset_ram_addr_wdata got %h/%h want 0/0", r_ram_addr, r_ram_wdata); end
        vectors++; if (r_rdata0 !== 8'hFF || r_rdata1 !== 8'hFF) begin miscompares++; $display("FAIL reset_rdata got %h/%h want ff/ff", r_rdata0, r_rdata1); end
    endtask

    task automatic test_single_read;
        apply_reset();
        addr0 = 22'h01234; we = 2'b00; req = 2'b01;
        step();
        vectors++; if (r_ram_req !== 1'b1) begin miscompares++; $display("FAIL read_ram_req got %b want 1", r_ram_req); end
        vectors++; if (r_ram_addr !== 22'h01234 || r_ram_we !== 1'b0) begin miscompares++; $display("FAIL read_ram_addr_we got %h/%b want 01234/0", r_ram_addr, r_ram_we); end
        step();
        vectors++; if (r_ack !== 2'b00 || r_ram_req !== 1'b1) begin miscompares++; $display("FAIL read_wait got ack %b req %b want 00/1", r_ack, r_ram_req); end
        ram_ack = 1'b1; ram_rdata = 8'h5A;
        step();
        ram_ack = 1'b0; req = 2'b00;
        vectors++; if (r_ack !== 2'b01 || r_err !== 2'b00) begin miscompares++; $display("FAIL read_ack got %b/%b want 01/00", r_ack, r_err); end
        vectors++; if (r_rdata0 !== 8'h5A || r_rdata1 !== 8'hFF) begin miscompares++; $display("FAIL read_rdata got %h/%h want 5a/ff", r_rdata0, r_rdata1); end
        vectors++; if (r_ram_req !== 1'b0) begin miscompares++; $display("FAIL read_done_ram_req got %b want 0", r_ram_req); end
        step();
        vectors++; if (r_ack !== 2'b00) begin miscompares++; $display("FAIL read_ack_pulse got %b want 00", r_ack); end
    endtask

    task automatic test_round_robin;
        logic exp_port;
        apply_reset();
        addr0 = 22'h10; addr1 = 22'h20; req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_port = (i % 2) == 1;
            step();
            vectors++; if (r_ram_addr !== (exp_port ? 22'h20 : 22'h10)) begin miscompares++; $display("FAIL rr_addr_%0d got %h want %h", i, r_ram_addr, exp_port ? 22'h20 : 22'h10); end
            ram_ack = 1'b1; ram_rdata = 8'(i + 1);
            step();
            ram_ack = 1'b0;
            vectors++; if (r_ack !== (exp_port ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rr_ack_%0d got %b want %b", i, r_ack, exp_port ? 2'b10 : 2'b01); end
            vectors++; if ((exp_port ? r_rdata1 : r_rdata0) !== 8'(i + 1)) begin miscompares++; $display("FAIL rr_rdata_%0d got %h want %h", i, exp_port ? r_rdata1 : r_rdata0, 8'(i + 1)); end
            step();
        end
        req = 2'b00;
        step();
    endtask

    task automatic test_fixed_priority;
        apply_reset();
        addr0 = 22'h10; addr1 = 22'h20; req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (f_ram_addr !== 22'h10) begin miscompares++; $display("FAIL fx_addr_%0d got %h want 000010", i, f_ram_addr); end
            ram_ack = 1'b1;
            step();
            ram_ack = 1'b0;
            vectors++; if (f_ack !== 2'b01) begin miscompares++; $display("FAIL fx_ack_%0d got %b want 01", i, f_ack); end
            if (i == 2) req = 2'b10;
            step();
        end
        step();
        vectors++; if (f_ram_addr !== 22'h20) begin miscompares++; $display("FAIL fx_addr_p1 got %h want 000020", f_ram_addr); end
        ram_ack = 1'b1;
        step();
        ram_ack = 1'b0; req = 2'b00;
        vectors++; if (f_ack !== 2'b10) begin miscompares++; $display("FAIL fx_ack_p1 got %b want 10", f_ack); end
        step();
    endtask

    task automatic test_write;
        apply_reset();
        addr1 = 22'h55; req = 2'b10;
        step();
        ram_ack = 1'b1; ram_rdata = 8'h77;
        step();
        ram_ack = 1'b0; req = 2'b00;
        vectors++; if (r_rdata1 !== 8'h77) begin miscompares++; $display("FAIL wr_preread got %h want 77", r_rdata1); end
        step();
        req = 2'b10; we = 2'b10; addr1 = 22'h3FFFFF; wdata1 = 8'hC3;
        step();
        vectors++; if (r_ram_we !== 1'b1 || r_ram_wdata !== 8'hC3) begin miscompares++; $display("FAIL wr_we_wdata got %b/%h want 1/c3", r_ram_we, r_ram_wdata); end
        vectors++; if (r_ram_addr !== 22'h3FFFFF) begin miscompares++; $display("FAIL wr_addr got %h want 3fffff", r_ram_addr); end
        ram_ack = 1'b1; ram_rdata = 8'hEE;
        step();
        ram_ack = 1'b0; req = 2'b00; we = 2'b00;
        vectors++; if (r_ack !== 2'b10 || r_err !== 2'b00) begin miscompares++; $display("FAIL wr_ack got %b/%b want 10/00", r_ack, r_err); end
        vectors++; if (r_rdata1 !== 8'h77) begin miscompares++; $display("FAIL wr_rdata_kept got %h want 77", r_rdata1); end
        step();
    endtask

    task automatic test_timeout;
        int busy_cycles;
        apply_reset();
        addr0 = 22'h99; req = 2'b01;
        step();
        ram_ack = 1'b1; ram_rdata = 8'h33;
        step();
        ram_ack = 1'b0; req = 2'b00;
        step();
        req = 2'b01;
        step();
        busy_cycles = 0;
        for (int k = 0; k < 20 && r_ram_req; k++) begin
            busy_cycles++;
            step();
        end
        req = 2'b00;
        vectors++; if (busy_cycles !== 4) begin miscompares++; $display("FAIL to_busy_cycles got %0d want 4", busy_cycles); end
        vectors++; if (r_ack !== 2'b01 || r_err !== 2'b01) begin miscompares++; $display("FAIL to_ack_err got %b/%b want 01/01", r_ack, r_err); end
        vectors++; if (r_rdata0 !== 8'hFF) begin miscompares++; $display("FAIL to_rdata got %h want ff", r_rdata0); end
        step();
        vectors++; if (r_err !== 2'b00) begin miscompares++; $display("FAIL to_err_pulse got %b want 00", r_err); end
        req = 2'b01;
        step();
        repeat (3) step();
        vectors++; if (r_ram_req !== 1'b1) begin miscompares++; $display("FAIL to_last_cycle_busy got %b want 1", r_ram_req); end
        ram_ack = 1'b1; ram_rdata = 8'h9C;
        step();
        ram_ack = 1'b0; req = 2'b00;
        vectors++; if (r_ack !== 2'b01 || r_err !== 2'b00) begin miscompares++; $display("FAIL to_edge_ack_err got %b/%b want 01/00", r_ack, r_err); end
        vectors++; if (r_rdata0 !== 8'h9C) begin miscompares++; $display("FAIL to_edge_rdata got %h want 9c", r_rdata0); end
        step();
    endtask

    task automatic test_reset_mid_access;
        apply_reset();
        addr0 = 22'h10; addr1 = 22'h20; req = 2'b01;
        step();
        ram_ack = 1'b1; ram_rdata = 8'h11;
        step();
        ram_ack = 1'b0; req = 2'b00;
        step();
        req = 2'b11;
        step();
        vectors++; if (r_ram_addr !== 22'h20) begin miscompares++; $display("FAIL rst_pre_grant got %h want 000020", r_ram_addr); end
        #3 rst_n = 1'b0;
        #1;
        vectors++; if (r_ram_req !== 1'b0 || r_ram_addr !== 22'h0) begin miscompares++; $display("FAIL rst_async got req %b addr %h want 0/0", r_ram_req, r_ram_addr); end
        vectors++; if (r_rdata0 !== 8'hFF) begin miscompares++; $display("FAIL rst_async_rdata got %h want ff", r_rdata0); end
        @(posedge clk);
        #1;
        vectors++; if (r_ack !== 2'b00 || r_ram_req !== 1'b0) begin miscompares++; $display("FAIL rst_held got ack %b req %b want 00/0", r_ack, r_ram_req); end
        #3 rst_n = 1'b1;
        step();
        vectors++; if (r_ram_req !== 1'b1 || r_ram_addr !== 22'h10) begin miscompares++; $display("FAIL rst_first_grant got req %b addr %h want 1/000010", r_ram_req, r_ram_addr); end
        ram_ack = 1'b1;
        step();
        ram_ack = 1'b0; req = 2'b00;
        vectors++; if (r_ack !== 2'b01) begin miscompares++; $display("FAIL rst_first_ack got %b want 01", r_ack); end
        step();
    endtask

    task automatic test_stray_and_held;
        int extra;
        apply_reset();
        ram_ack = 1'b1; ram_rdata = 8'hAA;
        step();
        step();
        ram_ack = 1'b0;
        vectors++; if (r_ack !== 2'b00 || r_ram_req !== 1'b0 || r_rdata0 !== 8'hFF) begin miscompares++; $display("FAIL stray_ack got ack %b req %b rdata %h want 00/0/ff", r_ack, r_ram_req, r_rdata0); end
        addr0 = 22'h77; req = 2'b01;
        step();
        ram_ack = 1'b1; ram_rdata = 8'h42;
        step();
        ram_ack = 1'b0;
        vectors++; if (r_ack !== 2'b01) begin miscompares++; $display("FAIL held_first_ack got %b want 01", r_ack); end
        step();
        vectors++; if (r_ack !== 2'b00) begin miscompares++; $display("FAIL held_idle_ack got %b want 00", r_ack); end
        step();
        vectors++; if (r_ram_req !== 1'b1) begin miscompares++; $display("FAIL held_new_access got %b want 1", r_ram_req); end
        req = 2'b00; ram_ack = 1'b1; ram_rdata = 8'h43;
        step();
        ram_ack = 1'b0;
        vectors++; if (r_ack !== 2'b01 || r_rdata0 !== 8'h43) begin miscompares++; $display("FAIL held_second_ack got %b/%h want 01/43", r_ack, r_rdata0); end
        extra = 0;
        repeat (6) begin
            step();
            if (r_ack !== 2'b00 || r_ram_req !== 1'b0) extra++;
        end
        vectors++; if (extra !== 0) begin miscompares++; $display("FAIL held_extra_activity got %0d want 0", extra); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_write();
        test_timeout();
        test_reset_mid_access();
        test_stray_and_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
